// File: rtl/cube_vector_gen.sv
// cube_vector_gen: walks every input vector covered by one PLA cube, lowest
// free-bit count first, through a valid/ready handshake.
// Optional self-checker enabled by defining CUBE_GEN_CHECK_EN; otherwise err = 0.
module cube_vector_gen #(
  parameter int N = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] care_mask,
  input  logic [N-1:0] care_val,
  output logic [N-1:0] vec_out,
  output logic         vec_valid,
  input  logic         vec_ready,
  output logic         busy,
  output logic         done,
  output logic [N:0]   vec_count,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] mask_q, val_q, cnt;
  logic [N-1:0] rem;
  logic         accept, last;

  // Deposit cnt bits into the don't-care positions, lowest position first.
  // Output is purely a function of latched state, so it naturally holds in
  // DONE/IDLE and reads zero after reset.
  always_comb begin
    vec_out = val_q & mask_q;
    rem     = cnt;
    for (int i = 0; i < N; i++) begin
      if (!mask_q[i]) begin
        vec_out[i] = rem[0];
        rem        = rem >> 1;
      end
    end
  end

  // cnt never exceeds 2^k-1, so the last vector is the one with every free bit set.
  assign last      = &(vec_out | mask_q);
  assign vec_valid = (state == RUN);
  assign busy      = (state == RUN) || (state == DONE);
  assign done      = (state == DONE);
  assign accept    = vec_valid & vec_ready;

  // Next-state: start only honoured in IDLE; DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, cube latch, free-bit counter and accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask_q    <= '0;
      val_q     <= '0;
      cnt       <= '0;
      vec_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        mask_q    <= care_mask;
        val_q     <= care_val;
        cnt       <= '0;
        vec_count <= '0;
      end else if (accept) begin
        vec_count <= vec_count + (N+1)'(1);
        if (!last) cnt <= cnt + N'(1);
      end
    end
  end

`ifdef CUBE_GEN_CHECK_EN
  logic [N-1:0] prev_cnt;
  logic         have_prev;
  logic         err_q;

  // Flag literal violations and non-sequential counter steps; sticky until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cnt  <= '0;
      have_prev <= 1'b0;
      err_q     <= 1'b0;
    end else if (state == IDLE && start) begin
      have_prev <= 1'b0;
    end else if (accept) begin
      if (((vec_out ^ val_q) & mask_q) != '0 ||
          ( have_prev && cnt != prev_cnt + N'(1)) ||
          (!have_prev && cnt != '0))
        err_q <= 1'b1;
      prev_cnt  <= cnt;
      have_prev <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cube_vector_gen.sv
// Directed bench for cube_vector_gen (N = 14) with hand-computed vectors.
module tb_cube_vector_gen;

  localparam int N = 14;

  logic         clk = 1'b0;
  logic         rst, start, vec_ready;
  logic [N-1:0] care_mask, care_val;
  logic [N-1:0] vec_out;
  logic         vec_valid, busy, done, err;
  logic [N:0]   vec_count;

  int checks = 0;
  int errors = 0;

  cube_vector_gen #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .care_mask(care_mask),
    .care_val(care_val), .vec_out(vec_out), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .busy(busy), .done(done),
    .vec_count(vec_count), .err(err)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [N-1:0] exp4 [4];
    logic [N-1:0] lastv;
    int           n;
    bit           seen_done;
    bit           seq_ok;

    exp4[0] = 14'h0004; exp4[1] = 14'h0006; exp4[2] = 14'h000C; exp4[3] = 14'h000E;

    rst = 1'b1; start = 1'b0; vec_ready = 1'b0;
    care_mask = '0; care_val = '0;
    #1; tick(); tick();
    rst = 1'b0;
    check("rst_valid", 32'(vec_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_count", 32'(vec_count), 0);
    check("rst_vec",   32'(vec_out), 0);
    check("rst_err",   32'(err), 0);

    // Fully specified cube: single vector.
    care_mask = 14'h3FFF; care_val = 14'h3D25; vec_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check("k0_valid", 32'(vec_valid), 1);
    check("k0_busy",  32'(busy), 1);
    check("k0_vec",   32'(vec_out), 32'h3D25);
    tick();
    check("k0_done",  32'(done), 1);
    check("k0_count", 32'(vec_count), 1);
    check("k0_nvalid", 32'(vec_valid), 0);
    check("k0_hold",  32'(vec_out), 32'h3D25);
    tick();
    check("k0_done_pulse", 32'(done), 0);
    check("k0_idle_busy",  32'(busy), 0);

    // Four free low bits, ready high: 16 back-to-back vectors.
    care_mask = 14'h3FF0; care_val = 14'h0000; start = 1'b1;
    tick(); start = 1'b0;
    seq_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (!vec_valid || vec_out != N'(i)) seq_ok = 1'b0;
      tick();
    end
    check("k4_seq",   32'(seq_ok), 1);
    check("k4_done",  32'(done), 1);
    check("k4_count", 32'(vec_count), 16);
    tick();
    check("k4_idle",  32'(done), 0);

    // Scattered free bits (1 and 3), ready toggling.
    care_mask = 14'h3FF5; care_val = 14'h0004; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec_ready = 1'b0;
      check($sformatf("sc_vec%0d", i), 32'(vec_out), 32'(exp4[i]));
      tick();
      check($sformatf("sc_hold%0d", i), 32'(vec_out), 32'(exp4[i]));
      check($sformatf("sc_valid%0d", i), 32'(vec_valid), 1);
      vec_ready = 1'b1;
      tick();
    end
    vec_ready = 1'b1;
    check("sc_done",  32'(done), 1);
    check("sc_count", 32'(vec_count), 4);
    tick();

    // Abort: three accepts, start ignored mid-run, then reset.
    care_mask = 14'h3FF0; care_val = 14'h0000; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    check("ab_count3", 32'(vec_count), 3);
    check("ab_vec3",   32'(vec_out), 3);
    vec_ready = 1'b0; care_mask = 14'h3FFF; care_val = 14'h1234; start = 1'b1;
    tick();
    check("ab_start_ign_vec",   32'(vec_out), 3);
    check("ab_start_ign_count", 32'(vec_count), 3);
    start = 1'b0; vec_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ab_busy",  32'(busy), 0);
    check("ab_valid", 32'(vec_valid), 0);
    check("ab_count", 32'(vec_count), 0);
    check("ab_done",  32'(done), 0);
    tick();
    check("ab_nodone", 32'(done), 0);

    // No literals: full 2^14 sweep with a cycle budget.
    care_mask = 14'h0000; care_val = 14'h1555; vec_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    n = 0; seen_done = 1'b0; seq_ok = 1'b1; lastv = '0;
    while (!seen_done && n < 20000) begin
      if (done) seen_done = 1'b1;
      else begin
        if (vec_out != N'(n)) seq_ok = 1'b0;
        lastv = vec_out;
        n++;
        tick();
      end
    end
    check("full_done",  32'(seen_done), 1);
    check("full_seq",   32'(seq_ok), 1);
    check("full_n",     32'(n), 16384);
    check("full_last",  32'(lastv), 32'h3FFF);
    check("full_count", 32'(vec_count), 32'h4000);
    check("full_err",   32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cube_vector_gen.md
CUBE_VECTOR_GEN -- requirements
Module: cube_vector_gen

Interface
REQ-001 SHALL have parameter N, default 14: input-vector width; one bit per PLA input x0..x(N-1).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to enumerate one cube; sampled only in IDLE.
REQ-005 SHALL have port care_mask, input, N bits: bit i = 1 means xi is a literal of the cube; bit i = 0 means xi is don't-care.
REQ-006 SHALL have port care_val, input, N bits: required polarity of each literal; ignored where care_mask = 0.
REQ-007 SHALL have port vec_out, output, N bits: current covered input vector, with bit i = xi.
REQ-008 SHALL have port vec_valid, output, 1 bit: vec_out holds a vector that has not yet been accepted.
REQ-009 SHALL have port vec_ready, input, 1 bit: the downstream consumer (cube detector or checker) accepts vec_out.
REQ-010 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the last vector is accepted.
REQ-012 SHALL have port vec_count, output, N+1 bits: number of vectors accepted since the last start.
REQ-013 SHALL have port err, output, 1 bit: sticky self-check flag (see Configuration).

Function
REQ-014 SHALL implement the states IDLE, RUN and DONE.
REQ-015 In IDLE with start = 1, SHALL latch care_mask and care_val, clear the free-bit counter cnt and vec_count, and enter RUN on the next edge.
REQ-016 SHALL form vec_out = (care_val & care_mask) | deposit(cnt, ~care_mask), using the latched values; deposit maps cnt bit j to the j-th lowest don't-care position.
REQ-017 SHALL set k = popcount(~care_mask) and enumerate cnt = 0 .. 2^k-1 in ascending order; cnt is N bits wide.
REQ-018 SHALL assert vec_valid in all RUN cycles; vec_valid is 0 in IDLE and DONE.
REQ-019 SHALL hold vec_out stable while vec_valid = 1 and vec_ready = 0.
REQ-020 On an accept (vec_valid & vec_ready), SHALL increment vec_count and, if cnt < 2^k-1, increment cnt in the same edge.
REQ-021 Accept latency SHALL be zero bubbles: with vec_ready tied high, a new vector is presented every cycle.
REQ-022 On accept of the last vector (cnt = 2^k-1), SHALL enter DONE; in DONE, done = 1 for exactly one cycle, then the block returns to IDLE.
REQ-023 With care_mask all ones (k = 0), SHALL emit exactly one vector equal to care_val.
REQ-024 With care_mask all zeros (k = N), SHALL emit 2^N vectors; vec_count SHALL reach 2^N without overflow.
REQ-025 SHALL ignore start in RUN and DONE; latched cube values SHALL NOT change mid-enumeration.
REQ-026 SHALL keep vec_out at its last value while in DONE and IDLE.

Reset
REQ-027 rst = 1 at a clock edge SHALL force IDLE and clear cnt, vec_count, vec_out, the latched mask and value, and err; vec_valid, busy and done SHALL be 0.
REQ-028 rst SHALL take priority over start and over any accept in the same cycle.
REQ-029 rst asserted mid-RUN SHALL abort the enumeration; no done pulse SHALL be produced.

Configuration
REQ-030 Macro CUBE_GEN_CHECK_EN defined: SHALL include a checker that flags any accepted vector where ((vec_out ^ care_val) & care_mask) != 0, or a duplicate where cnt does not increment by one; on either event err SHALL be set sticky until rst.
REQ-031 Macro CUBE_GEN_CHECK_EN undefined: no checker logic SHALL be present; err SHALL be tied to 0.

Verification
REQ-032 care_mask = 0x3FFF, care_val = 0x3D25, start pulse, vec_ready = 1 -> one vector 0x3D25, done 1 cycle later, vec_count = 1.
REQ-033 care_mask = 0x3FF0, care_val = 0x0000, vec_ready = 1 -> 0x0000..0x000F on 16 consecutive cycles, vec_count = 16, done pulse.
REQ-034 care_mask = 0x3FF5, care_val = 0x0004, vec_ready toggling 1/0 -> 0x0004, 0x0006, 0x000C, 0x000E, each held stable while ready = 0.
REQ-035 care_mask = 0x0000 -> 16384 vectors, last = 0x3FFF, vec_count = 0x4000, done.
REQ-036 rst pulsed after 3 accepts of the REQ-033 cube -> IDLE next cycle, vec_count = 0, no done; start asserted during RUN has no effect.
REQ-037 With CUBE_GEN_CHECK_EN defined, legal runs -> err stays 0.
